mem_port_arbiter: RTL and testbench

Two-port access controller in front of the byte-addressed data RAM: it shares the RAM between the CPU load/store unit (port C) and the debug/loader port (port D). It arbitrates round-robin and sequences each access as a single-cycle RAM enable. It converts size codes to the RAM's byte/half/word select, rejects misaligned or out-of-range accesses, and sign- or zero-extends load data. It sits between the MEM pipeline stage plus the debug loader and the RAM instance.

---
 rtl/mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the byte-addressed data RAM between the CPU (C) and debug (D) ports.
// Each grant becomes one registered RAM access cycle followed by a one-cycle ack to the winner.
module mem_port_arbiter #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic        c_signed,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_ena,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_switch,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic       PORT_C = 1'b0;
    localparam logic       PORT_D = 1'b1;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          last_q;
    logic          gnt_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          sgn_q;

    logic          any_req;
    logic          sel_gnt;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic          sel_sgn;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [2:0]    sel_bytes;
    logic [AW:0]   sel_last;
    logic          sel_err;
    logic [DW-1:0] load_data;

    logic          ram_ena_d, ram_we_d;
    logic [AW-1:0] ram_addr_d;
    logic [2:0]    ram_switch_d;
    logic [DW-1:0] ram_wdata_d;
    logic          c_ack_d, d_ack_d, c_err_d, d_err_d;
    logic [DW-1:0] c_rdata_d, d_rdata_d;

    function automatic logic [2:0] size_to_switch(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_switch = 3'b100;
            SZ_HALF: size_to_switch = 3'b010;
            SZ_WORD: size_to_switch = 3'b001;
            default: size_to_switch = 3'b000;
        endcase
    endfunction

    // Winner selection: alternate on contention, otherwise whoever asks.
    always_comb begin
        any_req   = c_req | d_req;
        sel_gnt   = (c_req & d_req) ? ~last_q : d_req;
        sel_we    = (sel_gnt == PORT_D) ? d_we     : c_we;
        sel_size  = (sel_gnt == PORT_D) ? d_size   : c_size;
        sel_sgn   = (sel_gnt == PORT_D) ? d_signed : c_signed;
        sel_addr  = (sel_gnt == PORT_D) ? d_addr   : c_addr;
        sel_wdata = (sel_gnt == PORT_D) ? d_wdata  : c_wdata;
    end

    // Alignment and range check; 33-bit end address avoids wrap near 2^32.
    always_comb begin
        case (sel_size)
            SZ_HALF: sel_bytes = 3'd2;
            SZ_WORD: sel_bytes = 3'd4;
            default: sel_bytes = 3'd1;
        endcase
        sel_last = {1'b0, sel_addr} + 33'(sel_bytes) - 33'd1;
        sel_err  = (sel_size == SZ_BAD)
                 | ((sel_size == SZ_HALF) & sel_addr[0])
                 | ((sel_size == SZ_WORD) & (sel_addr[1:0] != 2'b00))
                 | (sel_last >= 33'(DEPTH));
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: load_data = {{24{sgn_q & ram_rdata[7]}}, ram_rdata[7:0]};
            SZ_HALF: load_data = {{16{sgn_q & ram_rdata[15]}}, ram_rdata[15:0]};
            default: load_data = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = sel_err ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output; all zero unless a state drives them.
    always_comb begin
        ram_ena_d    = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = '0;
        ram_switch_d = 3'b000;
        ram_wdata_d  = '0;
        c_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        c_err_d      = 1'b0;
        d_err_d      = 1'b0;
        c_rdata_d    = '0;
        d_rdata_d    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (sel_err) begin
                        if (sel_gnt == PORT_D) begin
                            d_ack_d = 1'b1;
                            d_err_d = 1'b1;
                        end else begin
                            c_ack_d = 1'b1;
                            c_err_d = 1'b1;
                        end
                    end else begin
                        ram_ena_d    = 1'b1;
                        ram_we_d     = sel_we;
                        ram_addr_d   = sel_addr;
                        ram_switch_d = size_to_switch(sel_size);
                        ram_wdata_d  = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                if (gnt_q == PORT_D) begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = we_q ? '0 : load_data;
                end else begin
                    c_ack_d   = 1'b1;
                    c_rdata_d = we_q ? '0 : load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_switch <= 3'b000;
            ram_wdata  <= '0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            c_err      <= 1'b0;
            d_err      <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            ram_ena    <= ram_ena_d;
            ram_we     <= ram_we_d;
            ram_addr   <= ram_addr_d;
            ram_switch <= ram_switch_d;
            ram_wdata  <= ram_wdata_d;
            c_ack      <= c_ack_d;
            d_ack      <= d_ack_d;
            c_err      <= c_err_d;
            d_err      <= d_err_d;
            c_rdata    <= c_rdata_d;
            d_rdata    <= d_rdata_d;
        end
    end

    // Grant bookkeeping; pointer starts at D so C wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_D;
            gnt_q  <= PORT_C;
            we_q   <= 1'b0;
            size_q <= SZ_BYTE;
            sgn_q  <= 1'b0;
        end else if ((state_q == IDLE) && any_req) begin
            last_q <= sel_gnt;
            gnt_q  <= sel_gnt;
            we_q   <= sel_we;
            size_q <= sel_size;
            sgn_q  <= sel_sgn;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte RAM model behind the RAM port.
module tb_mem_port_arbiter;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_signed;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic        c_ack, c_err;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_signed;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        ram_ena, ram_we;
    logic [31:0] ram_addr;
    logic [2:0]  ram_switch;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [0:DEPTH-1];
    logic        mem_init;
    logic [9:0]  a0, a1, a2, a3;

    mem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_signed(c_signed),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_switch(ram_switch),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign a0 = ram_addr[9:0];
    assign a1 = a0 + 10'd1;
    assign a2 = a0 + 10'd2;
    assign a3 = a0 + 10'd3;

    always_comb begin
        case (ram_switch)
            3'b100:  ram_rdata = {24'h0, mem[a0]};
            3'b010:  ram_rdata = {16'h0, mem[a0], mem[a1]};
            3'b001:  ram_rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: ram_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            mem[32'h20] <= 8'hCA; mem[32'h21] <= 8'hFE; mem[32'h22] <= 8'hBA; mem[32'h23] <= 8'hBE;
        end else if (ram_ena && ram_we) begin
            case (ram_switch)
                3'b100: mem[a0] <= ram_wdata[7:0];
                3'b010: begin mem[a0] <= ram_wdata[15:8]; mem[a1] <= ram_wdata[7:0]; end
                3'b001: begin
                    mem[a0] <= ram_wdata[31:24]; mem[a1] <= ram_wdata[23:16];
                    mem[a2] <= ram_wdata[15:8];  mem[a3] <= ram_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    task automatic idle_inputs;
        c_req = 0; c_we = 0; c_size = 2'b00; c_signed = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_size = 2'b00; d_signed = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
    endtask

    // One access on a port; lat is cycles from the granting edge to the ack cycle (99 on timeout).
    task automatic access(input bit port, input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output bit ena_seen, output logic [2:0] sw_seen, output logic we_seen);
        @(posedge clk); #1;
        if (port == 1'b0) begin
            c_req = 1; c_we = we; c_size = size; c_signed = sgn; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = 1; d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
        end
        lat = 99; rdata = 32'h0; err = 1'b0; ena_seen = 0; sw_seen = 3'b000; we_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ram_ena) begin ena_seen = 1; sw_seen = ram_switch; we_seen = ram_we; end
            if ((port == 1'b0 && c_ack) || (port == 1'b1 && d_ack)) begin
                lat = i - 1;
                rdata = port ? d_rdata : c_rdata;
                err = port ? d_err : c_err;
                break;
            end
        end
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        c_req = 1; d_req = 1; c_size = 2'b10; d_size = 2'b10;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({c_ack, d_ack, c_err, d_err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ack_err: got %b expected 0000", {c_ack, d_ack, c_err, d_err});
        end
        n_cmp++;
        if ({c_rdata, d_rdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", c_rdata, d_rdata);
        end
        n_cmp++;
        if ({ram_ena, ram_we, ram_addr, ram_switch, ram_wdata} !== 69'h0) begin
            n_bad++; $display("FAIL reset_ram: ena=%b we=%b addr=%h sw=%b wdata=%h expected all 0",
                              ram_ena, ram_we, ram_addr, ram_switch, ram_wdata);
        end
        idle_inputs();
        #1 rst_n = 1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lt; bit en; logic [2:0] sw; logic wv;
        access(0, 1, 2'b10, 0, 32'h10, 32'h11223344, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (lt !== 2) begin n_bad++; $display("FAIL word_store_lat: got %0d expected 2", lt); end
        n_cmp++;
        if (er !== 1'b0) begin n_bad++; $display("FAIL word_store_err: got %b expected 0", er); end
        n_cmp++;
        if (sw !== 3'b001 || wv !== 1'b1) begin
            n_bad++; $display("FAIL word_store_ram: switch=%b we=%b expected 001/1", sw, wv);
        end
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL word_store_rdata: got %h expected 0", rd); end
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h11223344) begin n_bad++; $display("FAIL word_load: got %h expected 11223344", rd); end
        n_cmp++;
        if (lt !== 2 || er !== 1'b0) begin
            n_bad++; $display("FAIL word_load_lat_err: lat=%0d err=%b expected 2/0", lt, er);
        end
    endtask

    task automatic test_extension;
        logic [31:0] rd; logic er; int lt; bit en; logic [2:0] sw; logic wv;
        access(0, 0, 2'b00, 1, 32'h10, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h00000011) begin n_bad++; $display("FAIL byte_s_0x10: got %h expected 00000011", rd); end
        access(0, 1, 2'b00, 0, 32'h14, 32'h000000F0, rd, er, lt, en, sw, wv);
        access(0, 0, 2'b00, 1, 32'h14, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL byte_s_0x14: got %h expected FFFFFFF0", rd); end
        access(0, 0, 2'b00, 0, 32'h14, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h000000F0) begin n_bad++; $display("FAIL byte_u_0x14: got %h expected 000000F0", rd); end
        access(0, 0, 2'b01, 1, 32'h12, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h00003344) begin n_bad++; $display("FAIL half_s_0x12: got %h expected 00003344", rd); end
        access(1, 1, 2'b01, 0, 32'h16, 32'h00008001, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (sw !== 3'b010 || er !== 1'b0) begin
            n_bad++; $display("FAIL d_half_store: switch=%b err=%b expected 010/0", sw, er);
        end
        access(1, 0, 2'b01, 1, 32'h16, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL d_half_s_0x16: got %h expected FFFF8001", rd); end
        access(1, 0, 2'b01, 0, 32'h16, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h00008001) begin n_bad++; $display("FAIL d_half_u_0x16: got %h expected 00008001", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lt; bit en; logic [2:0] sw; logic wv;
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        bit          st [4];
        sz[0] = 2'b10; ad[0] = 32'h11;        st[0] = 1;
        sz[1] = 2'b01; ad[1] = 32'h13;        st[1] = 0;
        sz[2] = 2'b11; ad[2] = 32'h10;        st[2] = 1;
        sz[3] = 2'b10; ad[3] = 32'(DEPTH - 2); st[3] = 1;
        for (int k = 0; k < 4; k++) begin
            access(0, st[k], sz[k], 0, ad[k], 32'hAAAAAAAA, rd, er, lt, en, sw, wv);
            n_cmp++;
            if (er !== 1'b1) begin n_bad++; $display("FAIL err_case%0d_err: got %b expected 1", k, er); end
            n_cmp++;
            if (rd !== 32'h0) begin n_bad++; $display("FAIL err_case%0d_rdata: got %h expected 0", k, rd); end
            n_cmp++;
            if (lt !== 1) begin n_bad++; $display("FAIL err_case%0d_lat: got %0d expected 1", k, lt); end
            n_cmp++;
            if (en !== 1'b0) begin n_bad++; $display("FAIL err_case%0d_ena: got %b expected 0", k, en); end
        end
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h11223344) begin n_bad++; $display("FAIL err_readback_0x10: got %h expected 11223344", rd); end
        access(0, 0, 2'b01, 0, 32'(DEPTH - 2), 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_bad++; $display("FAIL half_top_edge: rdata=%h err=%b expected 0/0", rd, er);
        end
        access(0, 0, 2'b10, 0, 32'(DEPTH - 4), 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (er !== 1'b0 || lt !== 2) begin
            n_bad++; $display("FAIL word_top_edge: err=%b lat=%0d expected 0/2", er, lt);
        end
    endtask

    task automatic test_contention;
        int order [4]; logic [31:0] rdv [4];
        int nack = 0; int overlap = 0;
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_size = 2'b10; c_signed = 0; c_addr = 32'h10; c_wdata = 0;
        d_req = 1; d_we = 0; d_size = 2'b00; d_signed = 0; d_addr = 32'h14; d_wdata = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (c_ack && d_ack) overlap++;
            if (c_ack && nack < 4) begin order[nack] = 0; rdv[nack] = c_rdata; nack++; end
            else if (d_ack && nack < 4) begin order[nack] = 1; rdv[nack] = d_rdata; nack++; end
            if (nack == 4) break;
        end
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        n_cmp++;
        if (nack !== 4) begin n_bad++; $display("FAIL cont_count: got %0d acks expected 4", nack); end
        n_cmp++;
        if (overlap !== 0) begin n_bad++; $display("FAIL cont_overlap: got %0d expected 0", overlap); end
        for (int k = 0; k < nack; k++) begin
            n_cmp++;
            if (order[k] !== (k % 2)) begin
                n_bad++; $display("FAIL cont_order%0d: got port %0d expected %0d", k, order[k], k % 2);
            end
            n_cmp++;
            if (rdv[k] !== ((k % 2 == 0) ? 32'h11223344 : 32'h000000F0)) begin
                n_bad++; $display("FAIL cont_rdata%0d: got %h expected %h", k, rdv[k],
                                  (k % 2 == 0) ? 32'h11223344 : 32'h000000F0);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] rd; logic er; int lt; bit en; logic [2:0] sw; logic wv;
        int acks = 0;
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_size = 2'b10; c_signed = 0; c_addr = 32'h20; c_wdata = 32'hDEADBEEF;
        @(posedge clk); #2;
        n_cmp++;
        if (ram_ena !== 1'b1 || ram_we !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_access_entry: ena=%b we=%b expected 1/1", ram_ena, ram_we);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if (ram_ena !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ena_drop: got %b expected 0", ram_ena); end
        c_req = 0;
        repeat (3) begin @(negedge clk); if (c_ack || d_ack) acks++; end
        rst_n = 1;
        repeat (4) begin @(negedge clk); if (c_ack || d_ack) acks++; end
        n_cmp++;
        if (acks !== 0) begin n_bad++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks); end
        access(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lt, en, sw, wv);
        n_cmp++;
        if (rd !== 32'hCAFEBABE) begin n_bad++; $display("FAIL rst_mid_readback: got %h expected CAFEBABE", rd); end
    endtask

    task automatic test_back_to_back;
        int idx [3]; logic [31:0] rdv [3];
        int nack = 0;
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_size = 2'b00; c_signed = 0; c_addr = 32'h10; c_wdata = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (c_ack && nack < 3) begin idx[nack] = i; rdv[nack] = c_rdata; nack++; end
            if (nack == 3) break;
        end
        @(posedge clk); #1;
        c_req = 0;
        n_cmp++;
        if (nack !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d acks expected 3", nack); end
        if (nack == 3) begin
            n_cmp++;
            if (idx[0] !== 3) begin n_bad++; $display("FAIL b2b_first: got cycle %0d expected 3", idx[0]); end
            n_cmp++;
            if (idx[1] - idx[0] !== 3) begin n_bad++; $display("FAIL b2b_gap1: got %0d expected 3", idx[1] - idx[0]); end
            n_cmp++;
            if (idx[2] - idx[1] !== 3) begin n_bad++; $display("FAIL b2b_gap2: got %0d expected 3", idx[2] - idx[1]); end
            n_cmp++;
            if (rdv[2] !== 32'h00000011) begin n_bad++; $display("FAIL b2b_rdata: got %h expected 00000011", rdv[2]); end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        mem_init = 1;
        @(posedge clk); #1;
        mem_init = 0;
        test_reset();
        test_word();
        test_extension();
        test_errors();
        apply_reset();
        test_contention();
        test_reset_mid_access();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
